// File: rtl/load_store_unit.sv
// Byte-serial RISC-V load/store initiator driving a byte-wide memory port, little-endian order.
// Optional macro MISALIGN_TRAP_EN: misaligned lh/lhu/sh/lw/sw get an error response with no memory traffic.
module load_store_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  reqValid,
  output logic                  reqReady,
  input  logic                  reqWrite,
  input  logic [2:0]            funct3,
  input  logic [31:0]           reqAddr,
  input  logic [31:0]           reqWdata,
  output logic                  respValid,
  output logic [31:0]           respRdata,
  output logic                  respError,
  output logic                  memReq,
  output logic                  memWe,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [7:0]            memWdata,
  input  logic                  memAck,
  input  logic [7:0]            memRdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                stateR, stateNxt;
  logic [ADDR_WIDTH-1:0] addrR, addrNxt;
  logic [31:0]           wdataR, wdataNxt;
  logic                  writeR, writeNxt;
  logic [2:0]            funct3R, funct3Nxt;
  logic [1:0]            lastIdxR, lastIdxNxt;
  logic [1:0]            idxR, idxNxt;
  logic [31:0]           assemblyR, assemblyNxt;
  logic                  memReqNxt, memWeNxt;
  logic [ADDR_WIDTH-1:0] memAddrNxt;
  logic [7:0]            memWdataNxt;
  logic                  respValidNxt, respErrorNxt;
  logic [31:0]           respRdataNxt;
  logic                  reqMisaligned;
  logic [1:0]            idxInc;

  function automatic logic [1:0] lastIndex(input logic [1:0] size);
    case (size)
      2'b00:   lastIndex = 2'd0;
      2'b01:   lastIndex = 2'd1;
      default: lastIndex = 2'd3;
    endcase
  endfunction

  function automatic logic [7:0] pickByte(input logic [31:0] word, input logic [1:0] idx);
    case (idx)
      2'd0:    pickByte = word[7:0];
      2'd1:    pickByte = word[15:8];
      2'd2:    pickByte = word[23:16];
      2'd3:    pickByte = word[31:24];
      default: pickByte = word[7:0];
    endcase
  endfunction

  function automatic logic [31:0] putByte(input logic [31:0] word, input logic [1:0] idx,
                                          input logic [7:0] b);
    putByte = word;
    case (idx)
      2'd0:    putByte[7:0]   = b;
      2'd1:    putByte[15:8]  = b;
      2'd2:    putByte[23:16] = b;
      2'd3:    putByte[31:24] = b;
      default: putByte[7:0]   = b;
    endcase
  endfunction

  function automatic logic [31:0] extendLoad(input logic [2:0] f3, input logic [31:0] word);
    case (f3)
      3'b000:  extendLoad = {{24{word[7]}}, word[7:0]};
      3'b001:  extendLoad = {{16{word[15]}}, word[15:0]};
      3'b100:  extendLoad = {24'd0, word[7:0]};
      3'b101:  extendLoad = {16'd0, word[15:0]};
      default: extendLoad = word;
    endcase
  endfunction

  // Unsigned variants exist only for loads; 011 and 11x are never legal.
  function automatic logic isLegal(input logic write, input logic [2:0] f3);
    case (f3)
      3'b000, 3'b001, 3'b010: isLegal = 1'b1;
      3'b100, 3'b101:         isLegal = ~write;
      default:                isLegal = 1'b0;
    endcase
  endfunction

`ifdef MISALIGN_TRAP_EN
  assign reqMisaligned = ((funct3[1:0] == 2'b01) && reqAddr[0]) ||
                         ((funct3[1:0] == 2'b10) && (reqAddr[1:0] != 2'b00));
`else
  assign reqMisaligned = 1'b0;
`endif

  assign reqReady = (stateR == IDLE);
  assign idxInc   = idxR + 2'd1;

  // Next-state and next-output decode; every output is computed here and registered below.
  always_comb begin
    stateNxt     = stateR;
    addrNxt      = addrR;
    wdataNxt     = wdataR;
    writeNxt     = writeR;
    funct3Nxt    = funct3R;
    lastIdxNxt   = lastIdxR;
    idxNxt       = idxR;
    assemblyNxt  = assemblyR;
    memReqNxt    = memReq;
    memWeNxt     = memWe;
    memAddrNxt   = memAddr;
    memWdataNxt  = memWdata;
    respValidNxt = 1'b0;
    respErrorNxt = respError;
    respRdataNxt = respRdata;
    case (stateR)
      IDLE: begin
        if (reqValid) begin
          addrNxt     = reqAddr[ADDR_WIDTH-1:0];
          wdataNxt    = reqWdata;
          writeNxt    = reqWrite;
          funct3Nxt   = funct3;
          lastIdxNxt  = lastIndex(funct3[1:0]);
          idxNxt      = 2'd0;
          assemblyNxt = 32'd0;
          if (!isLegal(reqWrite, funct3) || reqMisaligned) begin
            stateNxt     = RESP;
            respValidNxt = 1'b1;
            respErrorNxt = 1'b1;
            respRdataNxt = 32'd0;
          end else begin
            stateNxt    = ACCESS;
            memReqNxt   = 1'b1;
            memWeNxt    = reqWrite;
            memAddrNxt  = reqAddr[ADDR_WIDTH-1:0];
            memWdataNxt = reqWdata[7:0];
          end
        end else begin
          stateNxt = IDLE;
        end
      end
      ACCESS: begin
        if (memAck) begin
          if (writeR) begin
            assemblyNxt = assemblyR;
          end else begin
            assemblyNxt = putByte(assemblyR, idxR, memRdata);
          end
          if (idxR == lastIdxR) begin
            stateNxt     = RESP;
            memReqNxt    = 1'b0;
            memWeNxt     = 1'b0;
            respValidNxt = 1'b1;
            respErrorNxt = 1'b0;
            respRdataNxt = writeR ? 32'd0 : extendLoad(funct3R, assemblyNxt);
          end else begin
            idxNxt      = idxInc;
            memAddrNxt  = addrR + ADDR_WIDTH'(idxInc);
            memWdataNxt = pickByte(wdataR, idxInc);
          end
        end else begin
          stateNxt = ACCESS;
        end
      end
      RESP: begin
        stateNxt = IDLE;
      end
      default: begin
        stateNxt  = IDLE;
        memReqNxt = 1'b0;
        memWeNxt  = 1'b0;
      end
    endcase
  end

  // State, context and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateR    <= IDLE;
      addrR     <= {ADDR_WIDTH{1'b0}};
      wdataR    <= 32'd0;
      writeR    <= 1'b0;
      funct3R   <= 3'd0;
      lastIdxR  <= 2'd0;
      idxR      <= 2'd0;
      assemblyR <= 32'd0;
      memReq    <= 1'b0;
      memWe     <= 1'b0;
      memAddr   <= {ADDR_WIDTH{1'b0}};
      memWdata  <= 8'd0;
      respValid <= 1'b0;
      respRdata <= 32'd0;
      respError <= 1'b0;
    end else begin
      stateR    <= stateNxt;
      addrR     <= addrNxt;
      wdataR    <= wdataNxt;
      writeR    <= writeNxt;
      funct3R   <= funct3Nxt;
      lastIdxR  <= lastIdxNxt;
      idxR      <= idxNxt;
      assemblyR <= assemblyNxt;
      memReq    <= memReqNxt;
      memWe     <= memWeNxt;
      memAddr   <= memAddrNxt;
      memWdata  <= memWdataNxt;
      respValid <= respValidNxt;
      respRdata <= respRdataNxt;
      respError <= respErrorNxt;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table, byte-wide memory model with
// programmable ack delay, and a response scoreboard; honours MISALIGN_TRAP_EN.
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        reqValid;
  logic        reqReady;
  logic        reqWrite;
  logic [2:0]  funct3;
  logic [31:0] reqAddr;
  logic [31:0] reqWdata;
  logic        respValid;
  logic [31:0] respRdata;
  logic        respError;
  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic [7:0]  memWdata;
  logic        memAck;
  logic [7:0]  memRdata;

  load_store_unit #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite), .funct3(funct3),
    .reqAddr(reqAddr), .reqWdata(reqWdata),
    .respValid(respValid), .respRdata(respRdata), .respError(respError),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
    .memAck(memAck), .memRdata(memRdata)
  );

  typedef struct {
    string       name;
    logic        write;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;
    bit          pulseBusy;
    logic [31:0] expRdata;
    logic        expErr;
    int          expLat;
    int          expBytes;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  logic [7:0]  mem [0:255];
  int          ackDelay;
  int          waitCnt;
  int          errors;
  int          checks;
  bit          prevValid;
  logic [31:0] prevRdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign memAck   = memReq && (waitCnt >= ackDelay);
  assign memRdata = mem[memAddr[7:0]];

  always @(posedge clk) begin
    if (!memReq || memAck) waitCnt <= 0;
    else                   waitCnt <= waitCnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic addVec(input string name, input logic write, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata, input int delay,
                        input bit pulse, input logic [31:0] expRdata, input logic expErr,
                        input int expLat, input int expBytes);
    vec_t v;
    v.name = name; v.write = write; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.delay = delay; v.pulseBusy = pulse; v.expRdata = expRdata; v.expErr = expErr;
    v.expLat = expLat; v.expBytes = expBytes;
    vecs.push_back(v);
  endtask

  task automatic runVec(input vec_t v);
    logic [31:0] addrLog[$];
    logic        weLog[$];
    logic [7:0]  wdLog[$];
    logic        holdValid;
    logic [31:0] holdAddr;
    logic        holdWe;
    logic [7:0]  holdWd;
    logic [31:0] ea;
    bit          done;
    exp_t        e;
    int          quiet;
    ackDelay = v.delay;
    @(negedge clk);
    chk({v.name, " reqReady idle"}, 32'(reqReady), 32'd1);
    chk({v.name, " respValid idle"}, 32'(respValid), 32'd0);
    if (prevValid) chk({v.name, " respRdata held"}, respRdata, prevRdata);
    reqValid = 1'b1; reqWrite = v.write; funct3 = v.f3; reqAddr = v.addr; reqWdata = v.wdata;
    sb.push_back('{v.expRdata, v.expErr, v.expLat});
    @(posedge clk);
    #1 reqValid = 1'b0;
    holdValid = 1'b0;
    done = 1'b0;
    for (int c = 1; c <= 60 && !done; c++) begin
      @(negedge clk);
      if (v.pulseBusy && c == 2) begin
        reqValid = 1'b1; reqWrite = 1'b1; funct3 = 3'b000; reqAddr = 32'h30;
        chk({v.name, " reqReady busy"}, 32'(reqReady), 32'd0);
      end else if (v.pulseBusy && c == 3) begin
        reqValid = 1'b0;
      end
      if (holdValid && memReq) begin
        chk({v.name, " memAddr stable"}, memAddr, holdAddr);
        chk({v.name, " memWe stable"}, 32'(memWe), 32'(holdWe));
        chk({v.name, " memWdata stable"}, 32'(memWdata), 32'(holdWd));
      end
      holdValid = 1'b0;
      if (memReq && memAck) begin
        addrLog.push_back(memAddr);
        weLog.push_back(memWe);
        wdLog.push_back(memWdata);
        if (memWe) mem[memAddr[7:0]] = memWdata;
      end else if (memReq) begin
        holdValid = 1'b1; holdAddr = memAddr; holdWe = memWe; holdWd = memWdata;
      end
      if (respValid) begin
        done = 1'b1;
        if (sb.size() == 0) begin
          chk({v.name, " unexpected response"}, 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk({v.name, " respRdata"}, respRdata, e.rdata);
          chk({v.name, " respError"}, 32'(respError), 32'(e.err));
          chk({v.name, " latency"}, 32'(c), 32'(e.lat));
        end
      end
    end
    if (!done) begin
      chk({v.name, " response timeout"}, 32'd0, 32'd1);
      void'(sb.pop_front());
    end
    chk({v.name, " byte count"}, 32'(addrLog.size()), 32'(v.expBytes));
    for (int k = 0; k < addrLog.size() && k < v.expBytes; k++) begin
      ea = v.addr + 32'(k);
      chk($sformatf("%s memAddr[%0d]", v.name, k), addrLog[k], ea);
      chk($sformatf("%s memWe[%0d]", v.name, k), 32'(weLog[k]), 32'(v.write));
      if (v.write) chk($sformatf("%s memWdata[%0d]", v.name, k), 32'(wdLog[k]), 32'(v.wdata[8*k +: 8]));
    end
    prevValid = 1'b1;
    prevRdata = v.expRdata;
    if (v.pulseBusy) begin
      quiet = 0;
      repeat (3) begin
        @(negedge clk);
        if (memReq || respValid) quiet++;
      end
      chk({v.name, " no stray request"}, 32'(quiet), 32'd0);
    end
  endtask

  initial begin
    int acks;
    int stray;
    errors = 0; checks = 0; prevValid = 1'b0; prevRdata = 32'd0; ackDelay = 0;
    reset = 1'b1; reqValid = 1'b0; reqWrite = 1'b0; funct3 = 3'd0; reqAddr = 32'd0; reqWdata = 32'd0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'h78; mem[8'h11] = 8'h56; mem[8'h12] = 8'h34; mem[8'h13] = 8'h12;
    mem[8'h04] = 8'h80; mem[8'h02] = 8'hFE; mem[8'h03] = 8'hFF;
    mem[8'hFE] = 8'h11; mem[8'hFF] = 8'h22; mem[8'h00] = 8'h33; mem[8'h01] = 8'h44;

    addVec("lw_0x10",    1'b0, 3'b010, 32'h10, 32'h0, 0, 1'b0, 32'h12345678, 1'b0, 5, 4);
    addVec("lb_0x4",     1'b0, 3'b000, 32'h4,  32'h0, 0, 1'b0, 32'hFFFFFF80, 1'b0, 2, 1);
    addVec("lbu_0x4",    1'b0, 3'b100, 32'h4,  32'h0, 0, 1'b0, 32'h00000080, 1'b0, 2, 1);
    addVec("lh_0x2",     1'b0, 3'b001, 32'h2,  32'h0, 0, 1'b0, 32'hFFFFFFFE, 1'b0, 3, 2);
    addVec("lhu_0x2",    1'b0, 3'b101, 32'h2,  32'h0, 0, 1'b0, 32'h0000FFFE, 1'b0, 3, 2);
    addVec("sw_0x20",    1'b1, 3'b010, 32'h20, 32'hDEADBEEF, 0, 1'b0, 32'h0, 1'b0, 5, 4);
    addVec("sb_0x20",    1'b1, 3'b000, 32'h20, 32'hDEADBEEF, 0, 1'b0, 32'h0, 1'b0, 2, 1);
    addVec("sh_0x22",    1'b1, 3'b001, 32'h22, 32'h1234CAFE, 0, 1'b0, 32'h0, 1'b0, 3, 2);
    addVec("lw_0x20",    1'b0, 3'b010, 32'h20, 32'h0, 0, 1'b0, 32'hCAFEBEEF, 1'b0, 5, 4);
    addVec("lh_wait3",   1'b0, 3'b001, 32'h2,  32'h0, 3, 1'b1, 32'hFFFFFFFE, 1'b0, 9, 2);
    addVec("ld_f3_011",  1'b0, 3'b011, 32'h10, 32'h0, 0, 1'b0, 32'h0, 1'b1, 1, 0);
    addVec("st_f3_100",  1'b1, 3'b100, 32'h40, 32'h55AA55AA, 0, 1'b0, 32'h0, 1'b1, 1, 0);
    addVec("lw_wrap",    1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 0, 1'b0, 32'h44332211, 1'b0, 5, 4);
`ifdef MISALIGN_TRAP_EN
    addVec("lw_0x1_mis", 1'b0, 3'b010, 32'h1,  32'h0, 0, 1'b0, 32'h0, 1'b1, 1, 0);
    addVec("lh_0x3_mis", 1'b0, 3'b001, 32'h3,  32'h0, 0, 1'b0, 32'h0, 1'b1, 1, 0);
`else
    addVec("lw_0x1_mis", 1'b0, 3'b010, 32'h1,  32'h0, 0, 1'b0, 32'h80FFFE44, 1'b0, 5, 4);
    addVec("lh_0x3_mis", 1'b0, 3'b001, 32'h3,  32'h0, 1, 1'b0, 32'hFFFF80FF, 1'b0, 5, 2);
`endif

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset memReq", 32'(memReq), 32'd0);
    chk("reset memWe", 32'(memWe), 32'd0);
    chk("reset memAddr", memAddr, 32'd0);
    chk("reset memWdata", 32'(memWdata), 32'd0);
    chk("reset respValid", 32'(respValid), 32'd0);
    chk("reset respRdata", respRdata, 32'd0);
    chk("reset respError", 32'(respError), 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) runVec(vecs[i]);

    // Abort an lw after two bytes have been acknowledged.
    ackDelay = 0;
    @(negedge clk);
    reqValid = 1'b1; reqWrite = 1'b0; funct3 = 3'b010; reqAddr = 32'h10;
    @(posedge clk);
    #1 reqValid = 1'b0;
    acks = 0;
    for (int c = 0; c < 20 && acks < 2; c++) begin
      @(negedge clk);
      if (memReq && memAck) acks++;
    end
    chk("abort acks seen", 32'(acks), 32'd2);
    reset = 1'b1;
    @(negedge clk);
    chk("abort memReq", 32'(memReq), 32'd0);
    chk("abort respValid", 32'(respValid), 32'd0);
    reset = 1'b0;
    stray = 0;
    repeat (4) begin
      @(negedge clk);
      if (respValid || memReq || !reqReady) stray++;
    end
    chk("abort quiet after release", 32'(stray), 32'd0);
    prevValid = 1'b1;
    prevRdata = 32'd0;
    runVec('{"lb_after_reset", 1'b0, 3'b000, 32'h4, 32'h0, 0, 1'b0, 32'hFFFFFF80, 1'b0, 2, 1});

    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Byte-serial load/store initiator between the execute stage and the byte-wide data memory port. It accepts one RISC-V load or store per handshake (lb/lh/lw/lbu/lhu/sb/sh/sw) and issues one memory transaction per byte in little-endian order. It assembles and sign- or zero-extends load data, then returns a single-cycle response. Misaligned accesses are handled natively unless compiled out.

## Interface
- ADDR_WIDTH, 32, width of memAddr; byte addresses wrap modulo 2^ADDR_WIDTH.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- reqValid  in  1  core presents a request.
- reqReady  out  1  unit idle; request accepted when reqValid & reqReady.
- reqWrite  in  1  1 = store, 0 = load.
- funct3  in  3  RISC-V size/sign code.
- reqAddr  in  32  byte address.
- reqWdata  in  32  store data; low bytes used for sb/sh.
- respValid  out  1  one-cycle completion pulse.
- respRdata  out  32  extended load data; 0 for stores and errors.
- respError  out  1  qualifies respValid; the request was rejected.
- memReq  out  1  byte transaction pending.
- memWe  out  1  write strobe, valid with memReq.
- memAddr  out  ADDR_WIDTH  byte address.
- memWdata  out  8  store byte.
- memAck  in  1  memory completes the current byte; ignored while memReq = 0.
- memRdata  in  8  read byte, valid in the memAck cycle.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- **IDLE**
  - reqReady = 1.
  - On acceptance, latch addr, wdata, write, funct3; set byte count N (000→1, 001→2, 010→4); set idx = 0; clear the assembly register.
  - Legal funct3: loads 000/001/010/100/101; stores 000/001/010.
  - Illegal funct3 → RESP with the error flag set, and no memory traffic.
- **ACCESS**
  - memReq = 1; memAddr = (addr + idx) mod 2^ADDR_WIDTH; memWe = write; memWdata = wdata[8*idx+7:8*idx].
  - On memAck: loads write memRdata into assembly[8*idx+7:8*idx].
  - If idx == N-1 → RESP; else idx++.
- **RESP**
  - respValid = 1 for exactly one cycle, then → IDLE.
  - Loads: respRdata is assembly extended from 8 or 16 bits; signed for 000/001, zero for 100/101; lw passes through.
  - Stores: respRdata = 0.
  - respError = error flag.
- reqReady = 0 in ACCESS and RESP; reqValid is ignored there.
- memAddr, memWe and memWdata hold stable while memReq = 1 and memAck = 0.
- respRdata and respError hold their value until the next RESP.

## Timing
- All outputs are registered, or decoded from registered state.
- Reset cycle: state ← IDLE; memReq, memWe, memAddr, memWdata, respValid, respRdata, respError all ← 0; reqReady = 1 from the first cycle after reset deasserts.
- Request accepted at edge T: memReq high in cycle T+1.
- With zero wait states, byte k completes in cycle T+1+k and respValid is high in cycle T+1+N. Latency: lb 2, lh 3, lw 5 cycles.
- Each memAck wait state adds one cycle per byte.
- Error responses: respValid at T+1, memReq never asserted.
- Back-to-back: the next request can be accepted in the cycle after respValid.
- Reset mid-operation: the access aborts. memReq = 0 after the reset edge, no respValid is produced, and bytes already written stay written.
- Address wrap: lw at 0xFFFFFFFE accesses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.

## Configuration
- Macro: MISALIGN_TRAP_EN.
- Defined: lh/lhu/sh with addr[0] ≠ 0, or lw/sw with addr[1:0] ≠ 0, go directly to RESP with respError = 1 and no memory traffic (latency 1).
- Undefined: misaligned accesses are serviced byte-serially like aligned ones, with no error.

## Test plan
- lw 0x10, memory bytes 0x10..0x13 = 78 56 34 12, memAck tied 1 → memAddr sequence 0x10, 0x11, 0x12, 0x13; respRdata = 0x12345678, respValid at T+5.
- Load extension, byte 0x04 = 0x80:
  - lb 0x4 → 0xFFFFFF80.
  - lbu 0x4 → 0x00000080.
  - lh 0x2 with bytes FE FF → 0xFFFFFFFE.
  - lhu 0x2 → 0x0000FFFE.
- Stores of reqWdata = 0xDEADBEEF:
  - sw to 0x20 → memWe = 1; writes EF, BE, AD, DE to 0x20..0x23; respRdata = 0.
  - sb to 0x20 → single write of EF.
- lh with memAck delayed 3 cycles per byte → memAddr/memWdata stable while waiting; respValid at T+9; a reqValid pulse during busy is not accepted.
- Misaligned and illegal requests:
  - lw 0x1 without the macro → accesses 0x1..0x4, respError = 0.
  - lw 0x1 with MISALIGN_TRAP_EN → respError = 1 at T+1, memReq never high.
  - Load funct3 = 011 → respError = 1 at T+1.
- reset asserted after 2 bytes of an lw → memReq = 0 next cycle, no respValid; after release reqReady = 1 and a new lb completes normally.
